// File: rtl/maxpool_pkg.sv
// Shared encodings and helpers for the streaming K x K / stride S max-pool.
package maxpool_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0000,
    ST_RUN   = 4'b0001,
    ST_FLUSH = 4'b0010,
    ST_DONE  = 4'b1111
  } mp_state_e;

  localparam logic [3:0] OP_MAXPOOL = 4'b0100;
  localparam logic [3:0] OP_ACK     = 4'b1111;

  localparam int unsigned LANE_MAX_W = 32;

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [LANE_MAX_W-1:0] lane_max(input logic [LANE_MAX_W-1:0] a,
                                                     input logic [LANE_MAX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_line_ram.sv
// Simple dual-port RAM, one write and one registered read per cycle.
// A same-address write in the read cycle is forwarded to the read data.
module maxpool_line_ram
  import maxpool_pkg::*;
#(
  parameter  int unsigned DEPTH = 64,
  parameter  int unsigned WIDTH = 128,
  localparam int unsigned AW    = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/maxpool_kxs_stream.sv
// Streaming K x K (K=2|3) stride S (1|2) max-pool over row-major beats of PAR_CH lanes.
// Optional same-padding is compiled in with `MAXPOOL_SAME_PAD_EN.
module maxpool_kxs_stream
  import maxpool_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PAR_CH    = 16,
  parameter int unsigned MAX_IMG_W = 416,
  parameter int unsigned MAX_GRP   = 64,
  parameter int unsigned CFG_W     = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               ctrl,
  output logic [3:0]               state,
  input  logic [CFG_W-1:0]         cfg_img_w,
  input  logic [6:0]               cfg_ch_grp,
  input  logic                     cfg_kernel,
  input  logic                     cfg_stride,
  input  logic                     cfg_same,
  output logic                     dma_read_start,
  output logic                     dma_write_start,
  input  logic [PAR_CH*DATA_W-1:0] S_Data,
  input  logic                     S_Valid,
  output logic                     S_Ready,
  output logic [PAR_CH*DATA_W-1:0] M_Data,
  output logic                     M_Valid,
  input  logic                     M_Ready,
  output logic                     intr_done
);

  localparam int unsigned BEAT_W = PAR_CH * DATA_W;
`ifdef MAXPOOL_SAME_PAD_EN
  localparam int unsigned LINE_COLS = MAX_IMG_W + 2;
`else
  localparam int unsigned LINE_COLS = MAX_IMG_W;
`endif
  localparam int unsigned LINE_DEPTH = LINE_COLS * MAX_GRP;
  localparam int unsigned LA_W       = addr_w(LINE_DEPTH);
  localparam int unsigned GA_W       = addr_w(MAX_GRP);

  function automatic logic [BEAT_W-1:0] beat_max(input logic [BEAT_W-1:0] a,
                                                 input logic [BEAT_W-1:0] b);
    logic [BEAT_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < PAR_CH; i++)
      m[i*DATA_W +: DATA_W] = DATA_W'(lane_max(LANE_MAX_W'(a[i*DATA_W +: DATA_W]),
                                               LANE_MAX_W'(b[i*DATA_W +: DATA_W])));
    return m;
  endfunction

  mp_state_e          st_q, st_d;
  logic [CFG_W-1:0]   w_q, e_q, r_q, c_q, km1, e_start;
  logic [6:0]         g_q, g_cnt;
  logic               k3_q, s2_q, pos_left;
  logic [LA_W-1:0]    la_q, s1_la;
  logic [GA_W-1:0]    s1_g;
  logic               s1_valid, s1_emit;
  logic [BEAT_W-1:0]  s1_data, vmax, hmax;
  logic [2*BEAT_W-1:0] lr_q, cr_q;
  logic               adv, start, active, pos_pad, take_in, gen, step;
  logic               grp_end, row_end, last_in, emit0, wr_en;

  assign state   = st_q;
  assign adv     = !M_Valid || M_Ready;
  assign start   = (st_q == ST_IDLE) && (ctrl == OP_MAXPOOL);
  assign active  = ((st_q == ST_RUN) || (st_q == ST_FLUSH)) && pos_left;
  assign S_Ready = (st_q == ST_RUN) && !pos_pad && adv;
  assign take_in = S_Ready && S_Valid;
  assign gen     = active && pos_pad && adv;
  assign step    = take_in || gen;
  assign wr_en   = s1_valid && adv;

`ifdef MAXPOOL_SAME_PAD_EN
  // Padded extent: S=1 adds K-1; S=2 adds K-2 plus one more for odd widths.
  always_comb begin
    e_start = cfg_img_w;
    if (cfg_same) begin
      if (!cfg_stride) e_start = cfg_img_w + (cfg_kernel ? CFG_W'(2) : CFG_W'(1));
      else             e_start = cfg_img_w + CFG_W'(cfg_kernel) + CFG_W'(cfg_img_w[0]);
    end
  end
  assign pos_pad = (r_q >= w_q) || (c_q >= w_q);
`else
  logic cfg_same_unused;
  assign cfg_same_unused = cfg_same;
  assign e_start = cfg_img_w;
  assign pos_pad = 1'b0;
`endif

  assign km1     = k3_q ? CFG_W'(2) : CFG_W'(1);
  assign grp_end = (g_cnt == g_q - 7'd1);
  assign row_end = grp_end && (c_q == e_q - CFG_W'(1));
  assign last_in = grp_end && (c_q == w_q - CFG_W'(1)) && (r_q == w_q - CFG_W'(1));
  // (x - (K-1)) is even iff x[0] equals the LSB of K-1, which is !k3.
  assign emit0   = (r_q >= km1) && (c_q >= km1) &&
                   !(s2_q && ((r_q[0] ^ !k3_q) || (c_q[0] ^ !k3_q)));

  // Entries pack {older, newer} prior taps; K=2 masks the older tap with zero.
  always_comb begin
    vmax = beat_max(beat_max(s1_data, lr_q[BEAT_W-1:0]), k3_q ? lr_q[2*BEAT_W-1:BEAT_W] : '0);
    hmax = beat_max(beat_max(vmax, cr_q[BEAT_W-1:0]), k3_q ? cr_q[2*BEAT_W-1:BEAT_W] : '0);
  end

  maxpool_line_ram #(.DEPTH(LINE_DEPTH), .WIDTH(2*BEAT_W)) u_line_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (s1_la),
    .wdata ({lr_q[BEAT_W-1:0], s1_data}),
    .re    (step),
    .raddr (la_q),
    .rdata (lr_q)
  );

  maxpool_line_ram #(.DEPTH(MAX_GRP), .WIDTH(2*BEAT_W)) u_col_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (s1_g),
    .wdata ({cr_q[BEAT_W-1:0], vmax}),
    .re    (step),
    .raddr (GA_W'(g_cnt)),
    .rdata (cr_q)
  );

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE:  if (ctrl == OP_MAXPOOL) st_d = ST_RUN;
      ST_RUN:   if (take_in && last_in) st_d = ST_FLUSH;
      ST_FLUSH: if (!pos_left && !s1_valid && adv) st_d = ST_DONE;
      ST_DONE:  if (ctrl == OP_ACK) st_d = ST_IDLE;
      default:  st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q            <= ST_IDLE;
      dma_read_start  <= 1'b0;
      dma_write_start <= 1'b0;
      intr_done       <= 1'b0;
      w_q      <= '0;
      e_q      <= '0;
      g_q      <= '0;
      k3_q     <= 1'b0;
      s2_q     <= 1'b0;
      r_q      <= '0;
      c_q      <= '0;
      g_cnt    <= '0;
      la_q     <= '0;
      pos_left <= 1'b0;
      s1_valid <= 1'b0;
      s1_emit  <= 1'b0;
      s1_data  <= '0;
      s1_la    <= '0;
      s1_g     <= '0;
      M_Valid  <= 1'b0;
      M_Data   <= '0;
    end else begin
      st_q            <= st_d;
      dma_read_start  <= start;
      dma_write_start <= start;
      intr_done       <= (st_q != ST_DONE) && (st_d == ST_DONE);
      if (start) begin
        w_q      <= cfg_img_w;
        e_q      <= e_start;
        g_q      <= cfg_ch_grp;
        k3_q     <= cfg_kernel;
        s2_q     <= cfg_stride;
        r_q      <= '0;
        c_q      <= '0;
        g_cnt    <= '0;
        la_q     <= '0;
        pos_left <= 1'b1;
      end else if (step) begin
        la_q  <= row_end ? '0 : la_q + LA_W'(1);
        g_cnt <= grp_end ? '0 : g_cnt + 7'd1;
        if (grp_end) c_q <= row_end ? '0 : c_q + CFG_W'(1);
        if (row_end) begin
          r_q <= r_q + CFG_W'(1);
          if (r_q == e_q - CFG_W'(1)) pos_left <= 1'b0;
        end
      end
      if (adv) begin
        s1_valid <= step;
        if (step) begin
          s1_data <= pos_pad ? '0 : S_Data;
          s1_la   <= la_q;
          s1_g    <= GA_W'(g_cnt);
          s1_emit <= emit0;
        end
        M_Valid <= s1_valid && s1_emit;
        if (s1_valid && s1_emit) M_Data <= hmax;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_kxs_stream.sv
// Scoreboard bench for maxpool_kxs_stream: window-based golden model, queued expectations.
module tb_maxpool_kxs_stream;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [3:0]   ctrl;
  logic [3:0]   state;
  logic [11:0]  cfg_img_w;
  logic [6:0]   cfg_ch_grp;
  logic         cfg_kernel, cfg_stride, cfg_same;
  logic         dma_read_start, dma_write_start;
  logic [127:0] S_Data;
  logic         S_Valid, S_Ready;
  logic [127:0] M_Data;
  logic         M_Valid, M_Ready;
  logic         intr_done;

  maxpool_kxs_stream dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .state(state),
    .cfg_img_w(cfg_img_w), .cfg_ch_grp(cfg_ch_grp), .cfg_kernel(cfg_kernel),
    .cfg_stride(cfg_stride), .cfg_same(cfg_same),
    .dma_read_start(dma_read_start), .dma_write_start(dma_write_start),
    .S_Data(S_Data), .S_Valid(S_Valid), .S_Ready(S_Ready),
    .M_Data(M_Data), .M_Valid(M_Valid), .M_Ready(M_Ready),
    .intr_done(intr_done)
  );

  int n_chk = 0, n_pass = 0;
  int n_intr = 0, n_dmar = 0, n_dmaw = 0, n_srlow = 0;
  logic [127:0] img [16][16][32];
  logic [127:0] in_q[$];
  logic [127:0] exp_q[$];

  always @(negedge clk) begin
    if (intr_done) n_intr++;
    if (dma_read_start) n_dmar++;
    if (dma_write_start) n_dmaw++;
    if (state == 4'b0001 && !S_Ready) n_srlow++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [127:0] bmax(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] m;
    for (int l = 0; l < 16; l++)
      m[l*8 +: 8] = (a[l*8 +: 8] > b[l*8 +: 8]) ? a[l*8 +: 8] : b[l*8 +: 8];
    return m;
  endfunction

  function automatic logic [127:0] pix(input int r, input int c, input int g, input int w);
    return (r < w && c < w) ? img[r][c][g] : 128'd0;
  endfunction

  task automatic fill(input int mode, input int w, input int g_n);
    for (int r = 0; r < w; r++)
      for (int c = 0; c < w; c++)
        for (int g = 0; g < g_n; g++) begin
          logic [127:0] b;
          for (int l = 0; l < 16; l++)
            b[l*8 +: 8] = (mode == 0) ? 8'(r*4 + c) : 8'($urandom_range(255));
          img[r][c][g] = b;
        end
  endtask

  task automatic build(input int w, input int g_n, input int k, input int s, input bit same);
    int o;
    logic [127:0] m;
    in_q.delete();
    exp_q.delete();
    for (int r = 0; r < w; r++)
      for (int c = 0; c < w; c++)
        for (int g = 0; g < g_n; g++) in_q.push_back(img[r][c][g]);
    if (same) o = (w + s - 1) / s;
    else      o = (w >= k) ? (w - k) / s + 1 : 0;
    for (int ro = 0; ro < o; ro++)
      for (int co = 0; co < o; co++)
        for (int g = 0; g < g_n; g++) begin
          m = '0;
          for (int i = 0; i < k; i++)
            for (int j = 0; j < k; j++) m = bmax(m, pix(ro*s + i, co*s + j, g, w));
          exp_q.push_back(m);
        end
  endtask

  task automatic start_op(input int w, input int g_n, input bit k3, input bit s2, input bit same);
    @(negedge clk);
    cfg_img_w = 12'(w); cfg_ch_grp = 7'(g_n);
    cfg_kernel = k3; cfg_stride = s2; cfg_same = same;
    ctrl = 4'b0100;
    @(negedge clk);
    ctrl = 4'b0000;
    check("start_run", 128'(state), 128'(4'b0001));
  endtask

  task automatic drive_in(input int n, input int vpct);
    int i = 0, guard = 0;
    while (i < n && guard < 60000) begin
      @(negedge clk);
      S_Valid = ($urandom_range(99) < vpct);
      S_Data  = in_q[i];
      #4;
      if (S_Valid && S_Ready) i++;
      guard++;
    end
    @(negedge clk);
    S_Valid = 1'b0;
    check("in_cnt", 128'(i), 128'(n));
  endtask

  task automatic mon_out(input int rpct);
    int cyc = 0;
    bit stalled = 0;
    logic [127:0] held = '0;
    while (exp_q.size() > 0 && cyc < 60000) begin
      @(negedge clk);
      M_Ready = ($urandom_range(99) < rpct);
      #4;
      if (M_Valid) begin
        if (stalled) check("stable", M_Data, held);
        if (M_Ready) begin
          check("beat", M_Data, exp_q.pop_front());
          stalled = 0;
        end else begin
          stalled = 1;
          held = M_Data;
        end
      end
      cyc++;
    end
    check("out_left", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic finish_op();
    int cyc = 0, extra = 0;
    while (state != 4'b1111 && cyc < 2000) begin
      @(negedge clk);
      M_Ready = 1'b1;
      #4;
      if (M_Valid) extra++;
      cyc++;
    end
    check("extra_out", 128'(extra), 128'd0);
    check("done_state", 128'(state), 128'(4'b1111));
    @(negedge clk);
    ctrl = 4'b1111;
    @(negedge clk);
    ctrl = 4'b0000;
    check("ack_idle", 128'(state), 128'(4'b0000));
  endtask

  task automatic run_test(input int w, input int g_n, input bit k3, input bit s2, input bit same,
                          input int vpct, input int rpct);
    int b_intr, b_dr, b_dw, n_in;
    build(w, g_n, k3 ? 3 : 2, s2 ? 2 : 1, same);
    n_in = in_q.size();
    b_intr = n_intr; b_dr = n_dmar; b_dw = n_dmaw;
    M_Ready = 1'b1;
    start_op(w, g_n, k3, s2, same);
    fork
      drive_in(n_in, vpct);
      mon_out(rpct);
    join
    finish_op();
    check("intr_once", 128'(n_intr - b_intr), 128'd1);
    check("dma_rd_once", 128'(n_dmar - b_dr), 128'd1);
    check("dma_wr_once", 128'(n_dmaw - b_dw), 128'd1);
  endtask

  initial begin
    int b_srlow;
    rst = 1'b0; ctrl = 4'b0000; cfg_img_w = '0; cfg_ch_grp = '0;
    cfg_kernel = 1'b0; cfg_stride = 1'b0; cfg_same = 1'b0;
    S_Valid = 1'b0; S_Data = '0; M_Ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 128'(state), 128'd0);
    check("rst_sready", 128'(S_Ready), 128'd0);
    check("rst_mvalid", 128'(M_Valid), 128'd0);
    check("rst_mdata", M_Data, 128'd0);
    check("rst_pulses", 128'({intr_done, dma_read_start, dma_write_start}), 128'd0);
    rst = 1'b1;
    @(negedge clk);

    // K=2 S=2 W=4 G=1, lanes r*4+c: expect 5,7,13,15
    fill(0, 4, 1);
    run_test(4, 1, 1'b0, 1'b1, 1'b0, 100, 100);

    // K=3 S=1 W=5 G=2 random, then same stimulus under back-pressure
    fill(1, 5, 2);
    run_test(5, 2, 1'b1, 1'b0, 1'b0, 100, 100);
    b_srlow = n_srlow;
    run_test(5, 2, 1'b1, 1'b0, 1'b0, 70, 50);
    check("sready_drop", 128'(n_srlow > b_srlow), 128'd1);

`ifdef MAXPOOL_SAME_PAD_EN
    fill(1, 13, 32);
    run_test(13, 32, 1'b0, 1'b0, 1'b1, 100, 100);
`endif

    // Reset in the middle of a run, then repeat the first case
    fill(0, 4, 1);
    build(4, 1, 2, 2, 1'b0);
    M_Ready = 1'b1;
    start_op(4, 1, 1'b0, 1'b1, 1'b0);
    drive_in(7, 100);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_state", 128'(state), 128'd0);
    check("midrst_mvalid", 128'(M_Valid), 128'd0);
    check("midrst_sready", 128'(S_Ready), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    run_test(4, 1, 1'b0, 1'b1, 1'b0, 100, 100);

    // W < K: inputs consumed, no outputs
    fill(1, 1, 3);
    run_test(1, 3, 1'b0, 1'b0, 1'b0, 100, 100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
